// File: rtl/alu_seq.sv
// Clocked ALU with a valid/ready input handshake, an iterative shift-add multiplier and an accumulator.
// Optional status flags (flag_z/flag_c/flag_v) are compiled in when ALU_FLAGS_EN is defined.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [WIDTH-1:0] acc
`ifdef ALU_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam bit MUL_ON = (MUL_EN != 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;

    logic accept;
    logic is_mul;
    logic start_mul;
    logic do_single;
    logic mul_done;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   alu_res;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_next;

    assign accept = in_valid & in_ready;
    assign is_mul = MUL_ON && (opcode == 3'b110);
    assign op_a   = acc_sel ? acc : a;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mul) state_next = BUSY;
            BUSY: if (cnt == LAST_STEP) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        in_ready  = 1'b0;
        start_mul = 1'b0;
        do_single = 1'b0;
        mul_done  = 1'b0;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                start_mul = in_valid & is_mul;
                do_single = in_valid & ~is_mul;
            end
            BUSY: mul_done = (cnt == LAST_STEP);
            default: ;
        endcase
    end

    // Single-cycle operations
    always_comb begin
        add_full = {1'b0, op_a} + {1'b0, b};
        sub_full = {1'b0, op_a} - {1'b0, b};
        case (opcode)
            3'b000:  alu_res = ~op_a;
            3'b001:  alu_res = op_a & b;
            3'b010:  alu_res = op_a | b;
            3'b011:  alu_res = add_full[WIDTH-1:0];
            3'b100:  alu_res = op_a ^ b;
            3'b101:  alu_res = sub_full[WIDTH-1:0];
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic alu_c;
    logic alu_v;

    always_comb begin
        alu_c = 1'b0;
        alu_v = 1'b0;
        if (opcode == 3'b011) begin
            alu_c = add_full[WIDTH];
            alu_v = (op_a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != op_a[WIDTH-1]);
        end else if (opcode == 3'b101) begin
            alu_c = sub_full[WIDTH];
            alu_v = (op_a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != op_a[WIDTH-1]);
        end
    end
`endif

    // Right-shifting shift-add: the multiplier sits in the low half of prod and is consumed LSB first
    assign step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
    assign prod_next = {step_sum, prod[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand     <= '0;
            prod      <= '0;
            cnt       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
`ifdef ALU_FLAGS_EN
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
`endif
        end else begin
            if (start_mul) begin
                mcand <= op_a;
                prod  <= {{WIDTH{1'b0}}, b};
                cnt   <= '0;
            end else if (state == BUSY) begin
                prod <= prod_next;
                cnt  <= cnt + 1'b1;
            end

            out_valid <= do_single | mul_done;

            if (do_single) begin
                result <= alu_res;
`ifdef ALU_FLAGS_EN
                flag_z <= (alu_res == '0);
                flag_c <= alu_c;
                flag_v <= alu_v;
`endif
            end else if (mul_done) begin
                result <= prod_next[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
                flag_z <= (prod_next[WIDTH-1:0] == '0);
                flag_c <= (prod_next[2*WIDTH-1:WIDTH] != '0);
                flag_v <= (prod_next[2*WIDTH-1:WIDTH] != '0);
`endif
            end

            // Clear wins over a simultaneous result load
            if (acc_clr) begin
                acc <= '0;
            end else if (do_single) begin
                acc <= alu_res;
            end else if (mul_done) begin
                acc <= prod_next[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios followed by random operations checked against an arithmetic model.
// A second instance built with MUL_EN=0 covers the disabled-multiplier behaviour.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [2:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         acc_sel;
    logic         acc_clr;

    logic         in_ready, out_valid;
    logic [W-1:0] result, acc;
    logic         in_ready0, out_valid0;
    logic [W-1:0] result0, acc0;
`ifdef ALU_FLAGS_EN
    logic         flag_z, flag_c, flag_v;
    logic         flag_z0, flag_c0, flag_v0;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] macc;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .acc_sel(acc_sel), .acc_clr(acc_clr),
        .result(result), .out_valid(out_valid), .acc(acc)
`ifdef ALU_FLAGS_EN
        , .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
`endif
    );

    alu_seq #(.WIDTH(W), .MUL_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .opcode(opcode), .a(a), .b(b), .acc_sel(acc_sel), .acc_clr(acc_clr),
        .result(result0), .out_valid(out_valid0), .acc(acc0)
`ifdef ALU_FLAGS_EN
        , .flag_z(flag_z0), .flag_c(flag_c0), .flag_v(flag_v0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input int unsigned x, input int unsigned y,
                                           input bit mul_en);
        int unsigned r;
        case (op)
            3'd0:    r = ~x;
            3'd1:    r = x & y;
            3'd2:    r = x | y;
            3'd3:    r = x + y;
            3'd4:    r = x ^ y;
            3'd5:    r = x - y;
            3'd6:    r = mul_en ? x * y : 0;
            default: r = 0;
        endcase
        return W'(r);
    endfunction

`ifdef ALU_FLAGS_EN
    // Returns {z, c, v}
    function automatic logic [2:0] fmodel(input logic [2:0] op, input int unsigned x, input int unsigned y);
        int sx, sy, s;
        logic z, c, v;
        sx = (x >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
        sy = (y >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
        z  = (model(op, x, y, 1'b1) == 0);
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd3: begin
                s = sx + sy;
                c = (x + y) >= (1 << W);
                v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            3'd5: begin
                s = sx - sy;
                c = x < y;
                v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            3'd6: begin
                c = ((x * y) >> W) != 0;
                v = c;
            end
            default: ;
        endcase
        return {z, c, v};
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic sel, input logic clr, input string tag);
        logic [W-1:0] opa, exp;
        opa = sel ? macc : va;
        exp = model(op, opa, vb, 1'b1);
        check({tag, "_ready_before"}, in_ready, 1'b1);
        opcode = op; a = va; b = vb; acc_sel = sel; acc_clr = clr; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; acc_sel = 1'b0; acc_clr = 1'b0;
        if (op == 3'd6) begin
            if (clr) macc = '0;
            check({tag, "_busy_ready"}, in_ready, 1'b0);
            check({tag, "_busy_acc"}, acc, macc);
            check({tag, "_nomul_result"}, result0, '0);
            check({tag, "_nomul_valid"}, out_valid0, 1'b1);
            check({tag, "_nomul_ready"}, in_ready0, 1'b1);
`ifdef ALU_FLAGS_EN
            check({tag, "_nomul_z"}, flag_z0, 1'b1);
`endif
            for (int i = 1; i < W; i++) begin
                tick();
                check({tag, "_busy_valid"}, out_valid, 1'b0);
                check({tag, "_busy_ready"}, in_ready, 1'b0);
            end
            tick();
            macc = exp;
        end else begin
            macc = clr ? '0 : exp;
            if (!sel) begin
                check({tag, "_dut0_result"}, result0, exp);
                check({tag, "_dut0_valid"}, out_valid0, 1'b1);
            end
        end
        check({tag, "_result"}, result, exp);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_ready"}, in_ready, 1'b1);
        check({tag, "_acc"}, acc, macc);
`ifdef ALU_FLAGS_EN
        check({tag, "_flags"}, {flag_z, flag_c, flag_v}, fmodel(op, opa, vb));
`endif
    endtask

    logic [2:0]   bops[4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [W-1:0] bexp[4] = '{8'hA9, 8'h14, 8'hF7, 8'hE3};

    initial begin
        rst = 1'b1; in_valid = 1'b0; opcode = '0; a = '0; b = '0; acc_sel = 1'b0; acc_clr = 1'b0;
        macc = '0;
        #2;
        check("rst_result", result, '0);
        check("rst_acc", acc, '0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_acc0", acc0, '0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_valid", out_valid, 1'b0);

        // Back-to-back logic ops with in_valid held high
        a = 8'h56; b = 8'hB5; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opcode = bops[i];
            tick();
            check("burst_result", result, bexp[i]);
            check("burst_valid", out_valid, 1'b1);
            check("burst_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        macc = 8'hE3;
        tick();
        check("burst_end_valid", out_valid, 1'b0);
        check("burst_acc", acc, 8'hE3);

        run_op(3'd3, 8'h56, 8'hB5, 1'b0, 1'b0, "add");
        check("add_const", result, 8'h0B);
        run_op(3'd5, 8'h56, 8'hB5, 1'b0, 1'b0, "sub");
        check("sub_const", result, 8'hA1);
`ifdef ALU_FLAGS_EN
        check("sub_cv", {flag_c, flag_v}, 2'b11);
`endif

        // Multiply with in_valid held high throughout the busy period
        opcode = 3'd6; a = 8'h56; b = 8'hB5; in_valid = 1'b1;
        tick();
        check("mul_ready_lo", in_ready, 1'b0);
        check("mul_valid_lo", out_valid, 1'b0);
        opcode = 3'd3; a = 8'h01;
        for (int i = 1; i < W; i++) begin
            tick();
            check("mul_wait_ready", in_ready, 1'b0);
            check("mul_wait_valid", out_valid, 1'b0);
        end
        tick();
        check("mul_result", result, 8'hCE);
        check("mul_valid", out_valid, 1'b1);
        check("mul_ready", in_ready, 1'b1);
        check("mul_acc", acc, 8'hCE);
`ifdef ALU_FLAGS_EN
        check("mul_flags", {flag_z, flag_c, flag_v}, 3'b011);
`endif
        in_valid = 1'b0;
        macc = 8'hCE;
        tick();
        check("mul_pulse_end", out_valid, 1'b0);
        check("mul_hold", result, 8'hCE);

        // Accumulator sequence
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        macc = '0;
        check("acc_clr_only", acc, '0);
        run_op(3'd3, 8'h10, 8'h01, 1'b0, 1'b0, "acc1");
        check("acc1_const", acc, 8'h11);
        run_op(3'd3, 8'h00, 8'h01, 1'b1, 1'b0, "acc2");
        check("acc2_const", acc, 8'h12);
        run_op(3'd3, 8'h00, 8'h01, 1'b1, 1'b1, "acc3");
        check("acc3_result", result, 8'h13);
        check("acc3_acc", acc, 8'h00);

        // Reset in the middle of a multiply
        run_op(3'd3, 8'h20, 8'h01, 1'b0, 1'b0, "pre_rst");
        opcode = 3'd6; a = 8'h56; b = 8'hB5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mrst_result", result, '0);
        check("mrst_acc", acc, '0);
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_ready", in_ready, 1'b1);
        macc = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("mrst_no_valid", out_valid, 1'b0);
        end
        run_op(3'd1, 8'hFF, 8'h0F, 1'b0, 1'b0, "and_after_rst");
        check("and_const", result, 8'h0F);

        run_op(3'd7, 8'h56, 8'hB5, 1'b0, 1'b0, "rsvd");
        check("rsvd_zero", result, 8'h00);
        run_op(3'd6, 8'h56, 8'hB5, 1'b0, 1'b0, "mul_vs_nomul");

        // Random operations
        for (int n = 0; n < 40; n++) begin
            logic [2:0]   rop;
            logic [W-1:0] ra, rb;
            logic         rsel, rclr;
            rop  = 3'($urandom_range(0, 7));
            ra   = W'($urandom);
            rb   = W'($urandom);
            rsel = 1'($urandom_range(0, 1));
            rclr = ($urandom_range(0, 7) == 0);
            run_op(rop, ra, rb, rsel, rclr, "rand");
            if ($urandom_range(0, 1) == 1) begin
                tick();
                check("rand_idle_valid", out_valid, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the lab's combinational 8-bit ALU. It adds registered results, a valid/ready input handshake, an output-valid pulse, ADD/SUB, an iterative shift-add multiplier and an internal accumulator usable as operand A. It sits between the DE1 switch/key capture logic and the LEDR/HEX display decoders.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
MUL_EN, 1, 1 = opcode 110 runs the multi-cycle multiply; 0 = opcode 110 returns zero in one cycle

Ports:
clk  input  1  system clock (CLOCK_50 at top level)
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept a new operation
opcode  input  3  operation select
a  input  WIDTH  operand A
b  input  WIDTH  operand B
acc_sel  input  1  1 = use accumulator instead of a as operand A (sampled at accept)
acc_clr  input  1  synchronous accumulator clear
result  output  WIDTH  registered result
out_valid  output  1  one-cycle pulse, result updated
acc  output  WIDTH  accumulator value

Behaviour:
- Reset (async, rst=1): result=0, acc=0, out_valid=0, in_ready=1, state=IDLE, multiplier regs=0. Reset mid-multiply aborts it; no out_valid is produced.
- Accept = in_valid & in_ready at a rising edge. Operand A = acc_sel ? acc : a, latched at accept.
- Opcodes: 000 ~A; 001 A&B; 010 A|B; 011 A+B (mod 2^WIDTH); 100 A^B; 101 A-B (mod 2^WIDTH); 110 MUL, low WIDTH bits of A*B; 111 reserved, result 0.
- FSM states IDLE, BUSY.
- IDLE: in_ready=1.
  - Single-cycle op accepted at edge k: result written at edge k; out_valid=1 during cycle k..k+1; remain in IDLE. Back-to-back accepts give one result per cycle.
  - MUL accepted at edge k (MUL_EN=1): latch multiplicand/multiplier, clear product, go BUSY; in_ready=0 from edge k.
- BUSY: one shift-add step per cycle, WIDTH steps, using a log2(WIDTH)+1-bit counter. The step at edge k+WIDTH writes result and sets out_valid=1 for one cycle, returns to IDLE, and in_ready=1 again. in_valid is ignored while BUSY. Latency is WIDTH edges.
- out_valid is 0 in every cycle not stated above.
- acc is loaded with the new result on every edge that writes result. acc_clr=1 sets acc=0 at that edge and wins over a simultaneous result write; result itself is still written.
- acc_sel with acc_clr at the same accept: the pre-clear acc value is used as operand A.
- No internal state depends on X operands when in_valid=0; a, b and opcode are don't-care outside accept.

Optional Feature:
ALU_FLAGS_EN: when defined, adds outputs flag_z, flag_c and flag_v (1 bit each, reset 0), registered with result.
- flag_z = (result==0).
- flag_c = carry-out for ADD, borrow (A<B unsigned) for SUB, 0 otherwise.
- flag_v = signed overflow for ADD/SUB, 0 otherwise.
- For MUL: flag_c = flag_v = (high WIDTH bits of product != 0).
When not defined, these ports and their logic are absent.

Test Plan:
- WIDTH=8, a=0x56, b=0xB5, opcodes 000/001/010/100 on consecutive cycles, in_valid held 1 -> result 0xA9, 0x14, 0xF7, 0xE3 on consecutive cycles; out_valid high 4 cycles; in_ready stays 1.
- ADD and SUB with a=0x56, b=0xB5 -> 0x0B and 0xA1. With ALU_FLAGS_EN: ADD c=1 v=0 z=0; SUB c=1 v=1 z=0.
- MUL a=0x56, b=0xB5 -> in_ready=0 for 8 cycles, in_valid ignored meanwhile; result=0xCE with single out_valid pulse 8 edges after accept. With flags: c=v=1.
- Accumulator: acc_clr, then ADD a=0x10 b=0x01 -> acc=0x11. Then acc_sel=1 ADD b=0x01 -> 0x12. Then acc_clr with an accept of ADD -> acc=0x00 and result=0x13.
- Assert rst for one cycle midway through a MUL -> outputs 0 immediately (async), no out_valid afterwards, in_ready=1. A following AND 0xFF&0x0F gives 0x0F.
- Opcode 111 and (MUL_EN=0) opcode 110 -> result 0x00 in one cycle, out_valid pulse, flag_z=1 if ALU_FLAGS_EN.
